// File: rtl/spi_command_transmitter.sv
// SPI mode-0 master that serialises Tetris command bytes from a small FIFO
// and captures the byte returned on sdo during each transfer.
//
// Ports:
//   game_clk        block clock, rising edge
//   reset_n         synchronous active-low reset
//   cmd_valid       command present, pushed when cmd_valid & cmd_ready
//   cmd_move        2-bit move code
//   cmd_piece       3-bit piece code (7 passed through unchanged)
//   cmd_move_valid  move-valid flag
//   cmd_ready       FIFO not full
//   fifo_count      occupied FIFO entries
//   sck/sdi/ce      SPI clock, serial data out (MSB first), chip enable
//   sdo             serial data in, sampled on sck rise
//   rx_data         last byte captured from sdo
//   rx_valid        one-cycle pulse when rx_data updates (same cycle ce falls)
//   busy            FSM not idle
module spi_command_transmitter #(
    parameter int SCK_HALF_PERIOD = 4,
    parameter int CE_GUARD        = 2,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                          game_clk,
    input  logic                          reset_n,
    input  logic                          cmd_valid,
    input  logic [1:0]                    cmd_move,
    input  logic [2:0]                    cmd_piece,
    input  logic                          cmd_move_valid,
    output logic                          cmd_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          sck,
    output logic                          sdi,
    output logic                          ce,
    input  logic                          sdo,
    output logic [7:0]                    rx_data,
    output logic                          rx_valid,
    output logic                          busy
);

    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CMAX = (SCK_HALF_PERIOD > CE_GUARD) ? SCK_HALF_PERIOD : CE_GUARD;
    localparam int CW   = $clog2(CMAX + 1);

    localparam logic [CW-1:0] GUARD_LAST = CW'(CE_GUARD - 1);
    localparam logic [CW-1:0] HALF_LAST  = CW'(SCK_HALF_PERIOD - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_HOLD,
        S_GAP
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [3:0]      r_tog;
    logic [7:0]      r_tx_shift;
    logic [7:0]      r_rx_shift;
    logic [7:0]      r_rx_data;
    logic            r_rx_valid;
    logic            r_sck;
    logic            r_sdi;
    logic            r_ce;

    logic [7:0]      r_mem [FIFO_DEPTH];
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [AW:0]     r_count;

    logic            w_ready;
    logic            w_push;
    logic            w_pop;
    logic [7:0]      w_byte;
    logic [7:0]      w_head;

    assign w_byte  = {2'b00, cmd_move_valid, cmd_piece, cmd_move};
    assign w_ready = (r_count < (AW + 1)'(FIFO_DEPTH));
    assign w_push  = cmd_valid & w_ready;
    assign w_pop   = (r_state == S_IDLE) && (r_count != '0);
    assign w_head  = r_mem[r_rptr];

    // Storage needs no reset: the pointers and count define what is valid.
    always_ff @(posedge game_clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= w_byte;
        end
    end

    always_ff @(posedge game_clk) begin
        if (!reset_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge game_clk) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_tog      <= '0;
            r_tx_shift <= '0;
            r_rx_shift <= '0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_sck      <= 1'b0;
            r_sdi      <= 1'b0;
            r_ce       <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_tx_shift <= w_head;
                        r_sdi      <= w_head[7];
                        r_ce       <= 1'b1;
                        r_cnt      <= '0;
                        r_tog      <= '0;
                        r_state    <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (r_cnt == GUARD_LAST) begin
                        r_cnt   <= '0;
                        r_state <= S_SHIFT;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_SHIFT: begin
                    if (r_cnt == HALF_LAST) begin
                        r_cnt <= '0;
                        r_tog <= r_tog + 1'b1;
                        if (!r_sck) begin
                            r_sck      <= 1'b1;
                            r_rx_shift <= {r_rx_shift[6:0], sdo};
                        end else begin
                            r_sck <= 1'b0;
                            // Falling toggles are odd; the 16th ends the byte.
                            if (r_tog == 4'd15) begin
                                r_state <= S_HOLD;
                            end else begin
                                r_tx_shift <= {r_tx_shift[6:0], 1'b0};
                                r_sdi      <= r_tx_shift[6];
                            end
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_HOLD: begin
                    if (r_cnt == GUARD_LAST) begin
                        r_cnt      <= '0;
                        r_ce       <= 1'b0;
                        r_sdi      <= 1'b0;
                        r_rx_data  <= r_rx_shift;
                        r_rx_valid <= 1'b1;
                        r_state    <= S_GAP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_GAP: begin
                    if (r_cnt == GUARD_LAST) begin
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready  = w_ready;
    assign fifo_count = r_count;
    assign sck        = r_sck;
    assign sdi        = r_sdi;
    assign ce         = r_ce;
    assign rx_data    = r_rx_data;
    assign rx_valid   = r_rx_valid;
    assign busy       = (r_state != S_IDLE);

endmodule
